// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the pipeline hazard controller:
//   state_t   - MDU sequencing states (RUN, MDU_WAIT, MDU_DONE)
//   REG_W     - width of a register specifier
//   REG_ZERO  - the hard-wired zero register, which never creates a hazard
//   reg_hit() - "this source operand is read and names the given register"
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        MDU_DONE = 2'd2
    } state_t;

    // True when a source operand is actually read and matches the destination.
    function automatic logic reg_hit(input logic             uses,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Groups the ID/EX hazard inputs and the stall/flush controls exchanged between
// the pipeline datapath (master) and the hazard controller (slave).
//   ID fields : id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, id_mdu_start_i
//   EX fields : ex_mem_read_i, ex_rd_i, ex_branch_taken_i
//   Controls  : pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o,
//               mdu_busy_o, stall_cycles_o[CNT_W]
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import pipeline_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_uses_rs_i;
    logic             id_uses_rt_i;
    logic             id_mdu_start_i;
    logic             ex_mem_read_i;
    logic [REG_W-1:0] ex_rd_i;
    logic             ex_branch_taken_i;

    logic             pc_stall_o;
    logic             if_id_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_bubble_o;
    logic             mdu_busy_o;
    logic [CNT_W-1:0] stall_cycles_o;

    // Pipeline side: supplies the decoded fields, consumes the controls.
    modport master (
        output id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, id_mdu_start_i,
               ex_mem_read_i, ex_rd_i, ex_branch_taken_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o,
               mdu_busy_o, stall_cycles_o
    );

    // Controller side.
    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, id_mdu_start_i,
               ex_mem_read_i, ex_rd_i, ex_branch_taken_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o,
               mdu_busy_o, stall_cycles_o
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector: the instruction in EX is a load whose
// destination (other than the zero register) is read by the instruction in ID.
//   id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i : ID source operands
//   ex_mem_read_i, ex_rd_i                       : EX load and its destination
//   load_use_o                                   : hazard present this cycle
// -----------------------------------------------------------------------------
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rd_i,
    output logic             load_use_o
);

    // Hazard only when a load targets a real register that ID actually reads.
    always_comb begin
        load_use_o = 1'b0;
        if (ex_mem_read_i && (ex_rd_i != REG_ZERO)) begin
            load_use_o = reg_hit(id_uses_rs_i, id_rs_i, ex_rd_i) ||
                         reg_hit(id_uses_rt_i, id_rt_i, ex_rd_i);
        end else begin
            load_use_o = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active-high; forces every output to 0
//   hz     : pipeline_hazard_ctrl_if.slave - ID/EX fields in, stall/flush
//            controls, MDU busy flag and stall-cycle counter out
// Priority: taken branch flush > load-use stall > MDU stall sequencing.
// Stall controls are combinational from inputs and registered state; the FSM,
// MDU down-counter and saturating stall counter are registered.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned CNT_W       = 16
) (
    input logic                  clk_i,
    input logic                  rst_i,
    pipeline_hazard_ctrl_if.slave hz
);

    // The cycle that starts the op is the first stall, so the counter covers the rest.
    localparam logic [7:0]       MDU_LOAD = 8'(MDU_LATENCY - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;

    logic load_use_s;
    logic stall_s;
    logic flush_s;
    logic bubble_s;
    logic busy_s;

    load_use_detect u_load_use_detect (
        .id_rs_i       (hz.id_rs_i),
        .id_rt_i       (hz.id_rt_i),
        .id_uses_rs_i  (hz.id_uses_rs_i),
        .id_uses_rt_i  (hz.id_uses_rt_i),
        .ex_mem_read_i (hz.ex_mem_read_i),
        .ex_rd_i       (hz.ex_rd_i),
        .load_use_o    (load_use_s)
    );

    // Output priority mux: branch flush, then load-use, then MDU stall.
    always_comb begin
        stall_s  = 1'b0;
        flush_s  = 1'b0;
        bubble_s = 1'b0;
        busy_s   = 1'b0;
        if (rst_i) begin
            stall_s  = 1'b0;
            flush_s  = 1'b0;
            bubble_s = 1'b0;
            busy_s   = 1'b0;
        end else begin
            busy_s = (state_r == MDU_WAIT);
            if (hz.ex_branch_taken_i) begin
                flush_s  = 1'b1;
                bubble_s = 1'b1;
            end else if (load_use_s && (state_r != MDU_WAIT)) begin
                stall_s  = 1'b1;
                bubble_s = 1'b1;
            end else if ((state_r == RUN) && hz.id_mdu_start_i) begin
                stall_s  = 1'b1;
                bubble_s = 1'b1;
            end else if (state_r == MDU_WAIT) begin
                stall_s  = 1'b1;
                bubble_s = 1'b1;
            end else begin
                // MDU_DONE ignores id_mdu_start_i so the op is not re-triggered.
                stall_s  = 1'b0;
                bubble_s = 1'b0;
            end
        end
    end

    // MDU sequencing next-state and down-counter; a taken branch aborts the wait.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (hz.ex_branch_taken_i) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 8'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (load_use_s) begin
                        // MDU start is deferred until the load-use bubble clears.
                        state_nxt_s = RUN;
                    end else if (hz.id_mdu_start_i) begin
                        state_nxt_s = MDU_WAIT;
                        cnt_nxt_s   = MDU_LOAD;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                MDU_WAIT: begin
                    if (cnt_r == 8'd1) begin
                        state_nxt_s = MDU_DONE;
                        cnt_nxt_s   = 8'd0;
                    end else begin
                        cnt_nxt_s = cnt_r - 8'd1;
                    end
                end
                MDU_DONE: begin
                    state_nxt_s = RUN;
                end
                default: begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = 8'd0;
                end
            endcase
        end
    end

    // State, down-counter and saturating stall-cycle counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= RUN;
            cnt_r       <= 8'd0;
            stall_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign hz.pc_stall_o     = stall_s;
    assign hz.if_id_stall_o  = stall_s;
    assign hz.if_id_flush_o  = flush_s;
    assign hz.id_ex_bubble_o = bubble_s;
    assign hz.mdu_busy_o     = busy_s;
    assign hz.stall_cycles_o = rst_i ? '0 : stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// cycle by cycle against a behavioural model that tracks "stall cycles still
// owed to the MDU op" rather than any FSM encoding.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int unsigned LAT     = 4;
    localparam int unsigned CW      = 16;
    localparam int unsigned CNT_SAT = 65535;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int          m_left = 0;    // MDU stall cycles still owed after this one
    bit          m_done = 1'b0; // op just finished; ignore its start request once
    int unsigned m_cnt  = 0;    // stall cycles so far, saturating

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz_if ();

    pipeline_hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (hz_if.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs just after the falling edge, compare against the
    // model, advance the model, then move to the next falling edge.
    task automatic cyc(input bit rst, input bit br, input bit mr, input logic [4:0] rd,
                       input bit urs, input logic [4:0] rs, input bit urt,
                       input logic [4:0] rt, input bit st);
        bit e_stall, e_flush, e_bub, e_busy, lu;
        int n_left;
        bit n_done;
        rst_i                   = rst;
        hz_if.ex_branch_taken_i = br;
        hz_if.ex_mem_read_i     = mr;
        hz_if.ex_rd_i           = rd;
        hz_if.id_uses_rs_i      = urs;
        hz_if.id_rs_i           = rs;
        hz_if.id_uses_rt_i      = urt;
        hz_if.id_rt_i           = rt;
        hz_if.id_mdu_start_i    = st;
        #1;
        e_stall = 1'b0; e_flush = 1'b0; e_bub = 1'b0; e_busy = 1'b0;
        n_left = 0; n_done = 1'b0;
        lu = mr && (rd != 5'd0) && ((urs && rs == rd) || (urt && rt == rd));
        if (!rst) begin
            e_busy = (m_left > 0);
            if (br) begin
                e_flush = 1'b1; e_bub = 1'b1;
            end else if (m_left > 0) begin
                e_stall = 1'b1; e_bub = 1'b1;
                n_left = m_left - 1;
                n_done = (n_left == 0);
            end else if (lu) begin
                e_stall = 1'b1; e_bub = 1'b1;
            end else if (!m_done && st) begin
                e_stall = 1'b1; e_bub = 1'b1;
                n_left = LAT - 1;
            end
        end
        check_val("pc_stall",     hz_if.pc_stall_o,     e_stall);
        check_val("if_id_stall",  hz_if.if_id_stall_o,  e_stall);
        check_val("if_id_flush",  hz_if.if_id_flush_o,  e_flush);
        check_val("id_ex_bubble", hz_if.id_ex_bubble_o, e_bub);
        check_val("mdu_busy",     hz_if.mdu_busy_o,     e_busy);
        check_val("stall_cycles", hz_if.stall_cycles_o, rst ? 32'd0 : m_cnt);
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_cnt = 0;
        end else begin
            m_left = n_left; m_done = n_done;
            if (e_stall && m_cnt < CNT_SAT) m_cnt++;
        end
        @(negedge clk_i);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    endtask

    initial begin
        @(negedge clk_i);
        // Reset state.
        cyc(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
        cyc(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
        idle();

        // Load-use on rs: one stall cycle, counter 0 -> 1.
        cyc(0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 0);
        idle();
        #1 check_val("lu_count", hz_if.stall_cycles_o, 32'd1);
        // No hazard: load into r0, or rs not read; rt match does stall.
        cyc(0, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0);
        cyc(0, 0, 1, 5'd5, 0, 5'd5, 0, 5'd0, 0);
        cyc(0, 0, 1, 5'd7, 0, 5'd1, 1, 5'd7, 0);
        idle();

        // MDU op with start held: 4 stalls, 3 busy, DONE without retrigger.
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        idle();
        #1 check_val("mdu_count", hz_if.stall_cycles_o, 32'd6);

        // Branch in the second MDU_WAIT cycle aborts the op.
        cyc(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        cyc(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        cyc(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        idle();
        // Branch beats load-use.
        cyc(0, 1, 1, 5'd3, 1, 5'd3, 0, 5'd0, 0);
        // Load-use defers a simultaneous MDU start.
        cyc(0, 0, 1, 5'd3, 1, 5'd3, 0, 5'd0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        idle();

        // Reset mid-MDU_WAIT, then a full new op.
        cyc(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        cyc(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        cyc(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        idle();
        #1 check_val("rst_mdu_count", hz_if.stall_cycles_o, 32'd4);

        // Randomized traffic with small register numbers so matches are common.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) == 0),
                $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0));
        end

        // Saturation: continuous load-use stall for more than 2^16 cycles.
        for (int i = 0; i < 65600; i++) cyc(0, 0, 1, 5'd9, 1, 5'd9, 0, 5'd0, 0);
        idle();
        #1 check_val("sat_count", hz_if.stall_cycles_o, 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It detects load-use hazards and sequences multi-cycle multiply/divide (MDU) stalls, and it drives the stall and flush controls of the PC, the IF/ID register and the ID/EX register. Taken-branch flushes resolved in EX take priority over every stall. It also keeps a saturating stall-cycle performance counter.

## Interface
- MDU_LATENCY, default 4: total front-end stall cycles per MDU op; legal range 2..255.
- CNT_W, default 16: width of the stall performance counter.

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- id_rs_i  in  5  rs field of instruction in ID
- id_rt_i  in  5  rt field of instruction in ID
- id_uses_rs_i  in  1  ID instruction reads rs
- id_uses_rt_i  in  1  ID instruction reads rt
- id_mdu_start_i  in  1  ID instruction is a multi-cycle MDU op
- ex_mem_read_i  in  1  EX instruction is a load
- ex_rd_i  in  5  destination register of EX instruction
- ex_branch_taken_i  in  1  branch in EX resolved taken
- pc_stall_o  out  1  hold PC
- if_id_stall_o  out  1  hold IF/ID contents
- if_id_flush_o  out  1  clear IF/ID to nop
- id_ex_bubble_o  out  1  load nop into ID/EX
- mdu_busy_o  out  1  FSM in MDU_WAIT
- stall_cycles_o  out  CNT_W  saturating count of cycles with pc_stall_o=1

## Operation
- Reset value of every output is 0. The FSM resets to RUN, the down-counter to 0 and stall_cycles_o to 0. All outputs are forced to 0 while rst_i=1.
- load_use is 1 when all of the following hold:
  - ex_mem_read_i=1
  - ex_rd_i != 0
  - (id_uses_rs_i and id_rs_i==ex_rd_i) or (id_uses_rt_i and id_rt_i==ex_rd_i)
- Priority, highest first:
  1. **Branch.** When ex_branch_taken_i=1: if_id_flush_o=1, id_ex_bubble_o=1, pc_stall_o=0, if_id_stall_o=0. The FSM goes to RUN and the counter clears, aborting any MDU wait because the ID op is on the wrong path.
  2. **Load-use.** When load_use=1 and the FSM is in RUN or MDU_DONE: pc_stall_o=1, if_id_stall_o=1, id_ex_bubble_o=1 for one cycle. In RUN, a simultaneous id_mdu_start_i is deferred and the FSM stays in RUN.
  3. **MDU.** Stall outputs are as for load-use. The FSM behaves as follows:
     - RUN with id_mdu_start_i=1: assert stall, load counter with MDU_LATENCY-1, go to MDU_WAIT.
     - MDU_WAIT: assert stall and mdu_busy_o=1. If counter==1, go to MDU_DONE; otherwise decrement the counter.
     - MDU_DONE: no MDU stall, and id_mdu_start_i is ignored so the op is not re-triggered. Go to RUN.
- Stall outputs depend combinationally on inputs and the registered state. The FSM, counter and stall_cycles_o are registered.
- stall_cycles_o increments on each cycle with pc_stall_o=1 and saturates at 2^CNT_W-1.

## Timing
- Load-use stall: stall outputs assert in the same cycle as the hazard. Latency is 0 cycles, duration exactly 1 cycle.
- MDU stall: exactly MDU_LATENCY consecutive stall cycles, starting in the cycle id_mdu_start_i is first seen in RUN. The MDU op leaves ID on the clock edge ending the MDU_DONE cycle.
- Branch flush: asserted in the same cycle as ex_branch_taken_i. IF/ID holds a nop after the next edge.
- Branch during MDU_WAIT: the flush is taken that cycle, the FSM is in RUN next cycle, and mdu_busy_o=0 next cycle.
- Reset asserted mid-MDU_WAIT: outputs go to 0 immediately. The FSM is in RUN with the counter at 0.
- Back-to-back MDU ops: the second op is seen in ID only after MDU_DONE, so it starts from RUN.

## Structure
- Package pipeline_ctrl_pkg holds:
  - state enum: RUN, MDU_WAIT, MDU_DONE
  - REG_ZERO = 5'd0
  - REG_W = 5
- Sub-module load_use_detect is combinational. It takes the ID and EX fields and outputs load_use.
- Top level holds the FSM, the down-counter (8 bits), the output priority mux and the performance counter.

## Test plan
- Load in EX with ex_rd_i=5; ID has id_rs_i=5, id_uses_rs_i=1 -> stall and bubble asserted for exactly 1 cycle; stall_cycles_o goes 0→1.
- Same load with ex_rd_i=0, or with id_uses_rs_i=0 -> no stall.
- MDU_LATENCY=4, id_mdu_start_i held high -> pc_stall_o=1 for 4 cycles, mdu_busy_o=1 for 3 cycles, then 1 MDU_DONE cycle with no stall and no retrigger; stall_cycles_o=4.
- ex_branch_taken_i=1 in the second MDU_WAIT cycle -> if_id_flush_o=1, pc_stall_o=0 that cycle; RUN next cycle.
- ex_branch_taken_i=1 together with load_use=1 -> flush wins, pc_stall_o=0.
- rst_i pulsed mid-MDU_WAIT -> all outputs 0 immediately; after release, a new MDU op gives a full 4-cycle stall. Separately, force 65535+ stall cycles -> stall_cycles_o stays at 16'hFFFF.
